// File: rtl/tt_ctrl_seq_pkg.sv
// Shared types and constants for the Tiny Tapeout control-pad sequencer.
// Imported by tt_ctrl_seq_if, tt_ctrl_seq_timer and tt_ctrl_seq.
package tt_ctrl_pkg;

  // Default width of a design address on the mux.
  localparam int unsigned TT_CTRL_ADDR_W = 10;

  // Legal range of cycles per protocol phase.
  localparam int unsigned TT_CTRL_HP_MIN = 1;
  localparam int unsigned TT_CTRL_HP_MAX = 255;

  // Phase timer width: wide enough for TT_CTRL_HP_MAX.
  localparam int unsigned TT_CTRL_TMR_W = 8;

  // Sequencer states, in protocol order.
  typedef enum logic [2:0] {
    IDLE,
    DIS,
    RST,
    REL,
    INC_H,
    INC_L,
    FIN
  } tt_ctrl_state_t;

  // Clamp a phase length into the legal range so the timer always expires.
  function automatic logic [TT_CTRL_TMR_W-1:0] hp_len(input int unsigned hp);
    int unsigned r;
    if (hp < TT_CTRL_HP_MIN) begin
      r = TT_CTRL_HP_MIN;
    end else if (hp > TT_CTRL_HP_MAX) begin
      r = TT_CTRL_HP_MAX;
    end else begin
      r = hp;
    end
    return r[TT_CTRL_TMR_W-1:0];
  endfunction

endpackage

// File: rtl/tt_ctrl_seq_if.sv
// Request/status bundle between a requester and tt_ctrl_seq.
// master: the requester (harness / self-test); slave: the sequencer.
interface tt_ctrl_seq_if
  import tt_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = TT_CTRL_ADDR_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ena;
  logic              done;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_valid;

  modport master (
    output req_valid,
    output req_addr,
    output req_ena,
    input  req_ready,
    input  done,
    input  cur_addr,
    input  cur_valid
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_ena,
    output req_ready,
    output done,
    output cur_addr,
    output cur_valid
  );

endinterface

// File: rtl/tt_ctrl_seq_timer.sv
// Phase down-counter for tt_ctrl_seq. Loading with len makes expire
// assert in the len-th cycle after the load edge; reloading on that
// same cycle starts the next phase without a gap.
module tt_ctrl_seq_timer
  import tt_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [TT_CTRL_TMR_W-1:0] len,
  output logic                     expire
);

  logic [TT_CTRL_TMR_W-1:0] cnt;

  // Count down from len to zero, holding at zero until the next load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len;
    end else if (cnt != '0) begin
      cnt <= cnt - TT_CTRL_TMR_W'(1);
    end
  end

  assign expire = (cnt == TT_CTRL_TMR_W'(1));

endmodule

// File: rtl/tt_ctrl_seq.sv
// Initiator for the Tiny Tapeout design-select control pads.
// Turns one "select design A" request into the ctl_ena / ctl_sel_rst_n /
// ctl_sel_inc pulse train expected by the tt_top mux controller.
// Optional: define TT_CTRL_SEQ_INCREMENTAL_EN to count forward from the
// currently selected design instead of resetting the select counter.
module tt_ctrl_seq
  import tt_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = TT_CTRL_ADDR_W,
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  tt_ctrl_seq_if.slave     bus,
  output logic             ctl_sel_rst_n,
  output logic             ctl_sel_inc,
  output logic             ctl_ena
);

  localparam logic [TT_CTRL_TMR_W-1:0] PHASE_LEN = hp_len(HALF_PERIOD);

  tt_ctrl_state_t    state;
  logic [ADDR_W:0]   n_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ena_q;
  logic              req_ready_q;
  logic              done_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic              cur_valid_q;

  logic              accept;
  logic              tmr_load;
  logic              tmr_expire;

`ifdef TT_CTRL_SEQ_INCREMENTAL_EN
  logic              inc_hit;
  logic              skip_q;

  assign inc_hit = cur_valid_q && (bus.req_addr >= cur_addr_q);
`endif

  assign accept = (state == IDLE) && bus.req_valid;

  // Restart the phase timer on entry to every timed state.
  always_comb begin
    tmr_load = 1'b0;
    case (state)
      IDLE:                         tmr_load = accept;
      DIS, RST, REL, INC_H, INC_L:  tmr_load = tmr_expire;
      default:                      tmr_load = 1'b0;
    endcase
  end

  tt_ctrl_seq_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .len    (PHASE_LEN),
    .expire (tmr_expire)
  );

  // Sequencer: state and every output are registered on the transition edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      n_q           <= '0;
      addr_q        <= '0;
      ena_q         <= 1'b0;
      req_ready_q   <= 1'b1;
      done_q        <= 1'b0;
      cur_addr_q    <= '0;
      cur_valid_q   <= 1'b0;
      ctl_sel_rst_n <= 1'b1;
      ctl_sel_inc   <= 1'b0;
      ctl_ena       <= 1'b0;
`ifdef TT_CTRL_SEQ_INCREMENTAL_EN
      skip_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q      <= bus.req_addr;
            ena_q       <= bus.req_ena;
            req_ready_q <= 1'b0;
            ctl_ena     <= 1'b0;
            state       <= DIS;
`ifdef TT_CTRL_SEQ_INCREMENTAL_EN
            skip_q      <= inc_hit;
            n_q         <= inc_hit ? ({1'b0, bus.req_addr} - {1'b0, cur_addr_q})
                                   : {1'b0, bus.req_addr};
`else
            n_q         <= {1'b0, bus.req_addr};
`endif
          end
        end

        DIS: begin
          if (tmr_expire) begin
`ifdef TT_CTRL_SEQ_INCREMENTAL_EN
            // Mux already sits at or below the target: count on from there.
            if (skip_q) begin
              if (n_q != '0) begin
                state       <= INC_H;
                ctl_sel_inc <= 1'b1;
              end else begin
                state       <= FIN;
                done_q      <= 1'b1;
                ctl_ena     <= ena_q;
                cur_addr_q  <= addr_q;
                cur_valid_q <= 1'b1;
              end
            end else begin
              state         <= RST;
              ctl_sel_rst_n <= 1'b0;
            end
`else
            state         <= RST;
            ctl_sel_rst_n <= 1'b0;
`endif
          end
        end

        RST: begin
          if (tmr_expire) begin
            state         <= REL;
            ctl_sel_rst_n <= 1'b1;
          end
        end

        REL: begin
          if (tmr_expire) begin
            if (n_q != '0) begin
              state       <= INC_H;
              ctl_sel_inc <= 1'b1;
            end else begin
              state       <= FIN;
              done_q      <= 1'b1;
              ctl_ena     <= ena_q;
              cur_addr_q  <= addr_q;
              cur_valid_q <= 1'b1;
            end
          end
        end

        INC_H: begin
          if (tmr_expire) begin
            state       <= INC_L;
            ctl_sel_inc <= 1'b0;
          end
        end

        INC_L: begin
          if (tmr_expire) begin
            n_q <= n_q - (ADDR_W + 1)'(1);
            // n_q still holds the pre-decrement count here.
            if (n_q > (ADDR_W + 1)'(1)) begin
              state       <= INC_H;
              ctl_sel_inc <= 1'b1;
            end else begin
              state       <= FIN;
              done_q      <= 1'b1;
              ctl_ena     <= ena_q;
              cur_addr_q  <= addr_q;
              cur_valid_q <= 1'b1;
            end
          end
        end

        FIN: begin
          state       <= IDLE;
          done_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end

        default: begin
          state         <= IDLE;
          req_ready_q   <= 1'b1;
          done_q        <= 1'b0;
          ctl_sel_rst_n <= 1'b1;
          ctl_sel_inc   <= 1'b0;
          ctl_ena       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.done      = done_q;
  assign bus.cur_addr  = cur_addr_q;
  assign bus.cur_valid = cur_valid_q;

endmodule

// File: tb/tb_tt_ctrl_seq.sv
// Directed self-checking bench for tt_ctrl_seq (HALF_PERIOD = 4).
// A pad monitor models the mux controller select counter and checks
// pulse widths and pad exclusivity; expected latencies come from a
// small request-level model.
module tb_tt_ctrl_seq;
  import tt_ctrl_pkg::*;

  localparam int unsigned AW     = 10;
  localparam int          HP     = 4;
  localparam int          BUDGET = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ctl_sel_rst_n;
  logic ctl_sel_inc;
  logic ctl_ena;

  tt_ctrl_seq_if #(.ADDR_W(AW)) bus ();

  tt_ctrl_seq #(.ADDR_W(AW), .HALF_PERIOD(HP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .ctl_sel_rst_n (ctl_sel_rst_n),
    .ctl_sel_inc   (ctl_sel_inc),
    .ctl_ena       (ctl_ena)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Pad monitor state
  int   inc_pulses  = 0;
  int   rst_low     = 0;
  int   width_bad   = 0;
  int   overlap_bad = 0;
  int   ena_bad     = 0;
  int   mux_sel     = 0;
  int   hi_len      = 0;
  int   lo_len      = 0;
  bit   in_low      = 1'b0;
  logic inc_prev    = 1'b0;

  // Request-level model of the selected design
  bit m_valid = 1'b0;
  int m_addr  = 0;

  // Mux-controller model plus pulse-width and exclusivity checks on the pads.
  always @(negedge clk) begin
    if (!rst_n) begin
      inc_prev = 1'b0;
      in_low   = 1'b0;
      hi_len   = 0;
      lo_len   = 0;
    end else begin
      if (!ctl_sel_rst_n) begin
        rst_low++;
        mux_sel = 0;
      end
      if (!ctl_sel_rst_n && ctl_sel_inc) overlap_bad++;
      if (ctl_ena && !bus.req_ready && !bus.done) ena_bad++;
      if (ctl_sel_inc && !inc_prev) begin
        inc_pulses++;
        mux_sel++;
        if (in_low && lo_len != HP) width_bad++;
        in_low = 1'b0;
        hi_len = 1;
      end else if (ctl_sel_inc) begin
        hi_len++;
      end else if (inc_prev) begin
        if (hi_len != HP) width_bad++;
        in_low = 1'b1;
        lo_len = 1;
      end else if (in_low) begin
        if (bus.done) begin
          if (lo_len != HP) width_bad++;
          in_low = 1'b0;
        end else begin
          lo_len++;
        end
      end
      inc_prev = ctl_sel_inc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected pulses / latency / select-reset cycles for a request to address a.
  task automatic plan(input int a, output int exp_lat, output int exp_pulses, output int exp_rst);
    bit full;
    full = 1'b1;
`ifdef TT_CTRL_SEQ_INCREMENTAL_EN
    if (m_valid && a >= m_addr) full = 1'b0;
`endif
    exp_pulses = full ? a : a - m_addr;
    exp_lat    = ((full ? 3 : 1) + 2 * exp_pulses) * HP + 1;
    exp_rst    = full ? HP : 0;
  endtask

  // Called one cycle after the accept edge; returns the cycle index of done.
  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < BUDGET) begin
      step();
      lat++;
    end
  endtask

  task automatic run_req(input string tag, input int a, input bit ena);
    int el, ep, er, lat, p0, r0;
    logic [31:0] av;
    plan(a, el, ep, er);
    p0 = inc_pulses;
    r0 = rst_low;
    av = a;
    bus.req_addr  = av[AW-1:0];
    bus.req_ena   = ena;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    chk({tag, ".ready_busy"}, bus.req_ready, 0);
    chk({tag, ".ena_dis"}, ctl_ena, 0);
    wait_done(lat);
    chk({tag, ".latency"}, lat, el);
    chk({tag, ".done"}, bus.done, 1);
    chk({tag, ".ctl_ena"}, ctl_ena, ena);
    chk({tag, ".cur_addr"}, bus.cur_addr, a);
    chk({tag, ".cur_valid"}, bus.cur_valid, 1);
    chk({tag, ".pulses"}, inc_pulses - p0, ep);
    chk({tag, ".rst_cycles"}, rst_low - r0, er);
    step();
    chk({tag, ".done_clr"}, bus.done, 0);
    chk({tag, ".ready_back"}, bus.req_ready, 1);
    chk({tag, ".ena_held"}, ctl_ena, ena);
    chk({tag, ".mux_sel"}, mux_sel, a);
    m_valid = 1'b1;
    m_addr  = a;
  endtask

  initial begin
    int el, ep, er, lat, n;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_ena   = 1'b0;
    rst_n         = 1'b0;
    repeat (3) step();

    chk("rst.sel_rst_n", ctl_sel_rst_n, 1);
    chk("rst.sel_inc", ctl_sel_inc, 0);
    chk("rst.ena", ctl_ena, 0);
    chk("rst.ready", bus.req_ready, 1);
    chk("rst.done", bus.done, 0);
    chk("rst.cur_addr", bus.cur_addr, 0);
    chk("rst.cur_valid", bus.cur_valid, 0);
    rst_n = 1'b1;
    step();

    // addr 0: done at cycle 13, no increments, select reset low 4 cycles
    run_req("a0", 0, 1'b1);
    // addr 5: full path done at cycle 53 (incremental build: 45)
    run_req("a5", 5, 1'b1);
    // same address, design left disabled
    run_req("a5_off", 5, 1'b0);

    // req_valid held high: second accept only in the cycle after done
    plan(1, el, ep, er);
    bus.req_addr  = 10'd1;
    bus.req_ena   = 1'b1;
    bus.req_valid = 1'b1;
    step();
    wait_done(lat);
    chk("hold.lat1", lat, el);
    chk("hold.ready_at_done", bus.req_ready, 0);
    step();
    chk("hold.ready_after", bus.req_ready, 1);
    chk("hold.done_clr", bus.done, 0);
    m_valid = 1'b1;
    m_addr  = 1;
    plan(1, el, ep, er);
    step();
    chk("hold.accepted", bus.req_ready, 0);
    chk("hold.ena_dis", ctl_ena, 0);
    bus.req_valid = 1'b0;
    wait_done(lat);
    chk("hold.lat2", lat, el);
    step();
    chk("hold.mux_sel", mux_sel, 1);

    // synchronous reset while ctl_sel_inc is high
    bus.req_addr  = 10'd5;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    n = 0;
    while (ctl_sel_inc !== 1'b1 && n < BUDGET) begin
      step();
      n++;
    end
    chk("mid.reached_inc", ctl_sel_inc, 1);
    rst_n = 1'b0;
    step();
    chk("mid.sel_rst_n", ctl_sel_rst_n, 1);
    chk("mid.sel_inc", ctl_sel_inc, 0);
    chk("mid.ena", ctl_ena, 0);
    chk("mid.ready", bus.req_ready, 1);
    chk("mid.done", bus.done, 0);
    chk("mid.cur_addr", bus.cur_addr, 0);
    chk("mid.cur_valid", bus.cur_valid, 0);
    rst_n   = 1'b1;
    m_valid = 1'b0;
    m_addr  = 0;
    step();

    // after reset: full path, 2 pulses, latency 29
    run_req("post_rst", 2, 1'b1);
    // all-ones address: 1023 pulses, no wrap (full path latency 8197)
    run_req("all_ones", 1023, 1'b1);

`ifdef TT_CTRL_SEQ_INCREMENTAL_EN
    run_req("inc_3", 3, 1'b1);
    // 3 -> 7: 4 pulses, no select reset, latency 37
    run_req("inc_3to7", 7, 1'b1);
    chk("inc_3to7.lat_hand", ((1 + 2 * 4) * HP) + 1, 37 + 0 * m_addr);
    // 7 -> 7: latency 5
    run_req("inc_7to7", 7, 1'b1);
    // 7 -> 2: full path, 2 pulses, latency 29
    run_req("inc_7to2", 2, 1'b1);
`endif

    chk("pads.overlap", overlap_bad, 0);
    chk("pads.ena_mid_seq", ena_bad, 0);
    chk("pads.inc_width", width_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
